// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// IF_FETCH_ALIGN_CHECK_EN adds the FAULT state for misaligned redirects.
package if_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0]        RESET_VEC_DEF = 32'h0000_0000;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FAULT
  } if_state_e;
`else
  typedef enum logic [1:0] {
    FETCH,
    HOLD
  } if_state_e;
`endif

  // One fetched word as it travels to the IF/ID register: {PC+4, instruction}
  typedef struct packed {
    logic [31:0]        pc_next;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and imem.
interface if_fetch_unit_if;

  logic                       imem_req;
  logic [31:0]                imem_addr;
  logic                       imem_ready;
  logic [if_pkg::INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_hold_buffer.sv
// One-entry skid register catching a fetch that completes while IF/ID is stalled.
module if_hold_buffer
  import if_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  // Flush wins over load so a redirect can discard a coincident return
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC register, fetch FSM and IF/ID output registers.
// IF_FETCH_ALIGN_CHECK_EN traps misaligned redirects in a sticky FAULT state.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0]        RESET_VEC = RESET_VEC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic [31:0]        pc_address_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               valid_out,
  output logic               fault
);

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d, pc_plus4, target_pc;
  logic [31:0]        out_pc_d;
  logic [INSTR_W-1:0] out_ins_d;
  logic               out_v_d;

  logic               buf_load, buf_unload, buf_flush, buf_valid;
  fetch_word_t        buf_din, buf_dout;

  assign pc_plus4       = pc_incr(pc_q);
  assign buf_din        = {pc_plus4, imem.imem_rdata};
  assign imem.imem_req  = !RST && (state_q == FETCH);
  assign imem.imem_addr = pc_q;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign target_pc  = redirect_pc;
  assign fault      = (state_q == FAULT);
`else
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign fault      = 1'b0;
`endif

  if_hold_buffer u_hold_buffer (
    .CLK    (CLK),
    .RST    (RST),
    .load   (buf_load),
    .unload (buf_unload),
    .flush  (buf_flush),
    .din    (buf_din),
    .dout   (buf_dout),
    .valid  (buf_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = pc_address_out;
    out_ins_d  = instruction_out;
    out_v_d    = valid_out;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_flush  = 1'b0;

    case (state_q)
      FETCH, HOLD: begin
        if (redirect) begin
          // Redirect beats stall and any returning data; pc_address_out is kept
          pc_d      = target_pc;
          buf_flush = 1'b1;
          out_ins_d = NOP_INSTR;
          out_v_d   = 1'b0;
          state_d   = FETCH;
`ifdef IF_FETCH_ALIGN_CHECK_EN
          if (misaligned) state_d = FAULT;
`endif
        end else if (state_q == HOLD) begin
          if (!stall) begin
            out_pc_d   = buf_dout.pc_next;
            out_ins_d  = buf_dout.instr;
            out_v_d    = buf_valid;
            buf_unload = 1'b1;
            state_d    = FETCH;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_plus4;
          if (stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            out_pc_d  = pc_plus4;
            out_ins_d = imem.imem_rdata;
            out_v_d   = 1'b1;
          end
        end else if (!stall) begin
          out_ins_d = NOP_INSTR;
          out_v_d   = 1'b0;
        end
      end
      default: begin
        // FAULT: everything frozen until RST
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= FETCH;
      pc_q            <= RESET_VEC;
      pc_address_out  <= '0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_address_out  <= out_pc_d;
      instruction_out <= out_ins_d;
      valid_out       <= out_v_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit against a program-order reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc_address_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        fault;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  if_fetch_unit_if imem ();
  assign imem.imem_ready = imem_ready;
  assign imem.imem_rdata = memf(imem.imem_addr);

  if_fetch_unit #(
    .RESET_VEC (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem            (imem),
    .pc_address_out  (pc_address_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .fault           (fault)
  );

  always #5 CLK = ~CLK;

  // Reference model: next address to fetch, fetched-but-unemitted addresses,
  // what the IF/ID register should hold, and the next address in program order.
  logic [31:0] m_pc;
  logic [31:0] held[$];
  logic [31:0] m_out_pc, m_out_ins;
  logic        m_out_v, m_fault, m_emit;
  logic [31:0] seq_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    stall = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0500;
    imem_ready = 1'b1;
    #1;
    chk("req_in_reset", {31'b0, imem.imem_req}, 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_pc_out", pc_address_out, 32'd0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", imem.imem_addr, 32'd0);
    m_pc = 32'd0;
    held.delete();
    m_out_pc = 32'd0;
    m_out_ins = NOP;
    m_out_v = 1'b0;
    m_fault = 1'b0;
    seq_next = 32'd0;
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic [31:0] a;
    logic        m_req;
    @(negedge CLK);
    RST = 1'b0;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_ready = rdy;
    #1;
    m_req = !m_fault && (held.size() == 0);
    chk("imem_req", {31'b0, imem.imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem.imem_addr, m_pc);

    m_emit = 1'b0;
    if (m_fault) begin
      m_emit = 1'b0;
    end else if (rd) begin
`ifdef IF_FETCH_ALIGN_CHECK_EN
      a = rpc;
      if (rpc[1:0] != 2'b00) m_fault = 1'b1;
`else
      a = {rpc[31:2], 2'b00};
`endif
      m_pc = a;
      seq_next = a;
      held.delete();
      m_out_ins = NOP;
      m_out_v = 1'b0;
    end else if (held.size() != 0) begin
      if (!st) begin
        a = held.pop_front();
        m_out_pc = a + 32'd4;
        m_out_ins = memf(a);
        m_out_v = 1'b1;
        m_emit = 1'b1;
      end
    end else if (rdy) begin
      if (st) held.push_back(m_pc);
      else begin
        m_out_pc = m_pc + 32'd4;
        m_out_ins = memf(m_pc);
        m_out_v = 1'b1;
        m_emit = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_out_ins = NOP;
      m_out_v = 1'b0;
    end

    @(posedge CLK);
    #1;
    chk("pc_address_out", pc_address_out, m_out_pc);
    chk("instruction_out", instruction_out, m_out_ins);
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_out_v});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    if (m_emit) begin
      chk("order_pc", pc_address_out, seq_next + 32'd4);
      chk("order_instr", instruction_out, memf(seq_next));
      seq_next = seq_next + 32'd4;
    end
  endtask

  initial begin
    logic        st, rd, rdy;
    logic [31:0] rpc;

    do_reset();

    // Straight-line fetch: 0, 4, 8
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_stream_pc", pc_address_out, 32'd12);
    chk("tp_stream_instr", instruction_out, memf(32'd8));

    // Stall three cycles with ready high, then release
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);
    chk("tp_stall_frozen", pc_address_out, 32'd12);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_release_pc", pc_address_out, 32'd16);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_resume_pc", pc_address_out, 32'd20);

    // Two cycles of memory not ready
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("tp_bubble_instr", instruction_out, NOP);

    // Redirect coincident with ready and stall
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_redir_pc", pc_address_out, 32'h0000_0104);
    chk("tp_redir_instr", instruction_out, memf(32'h0000_0100));

    // Wrap-around of the PC
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_wrap_pc", pc_address_out, 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("tp_wrap_next", pc_address_out, 32'd4);

    // Randomized interleaving of stall, ready and redirect
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
`ifdef IF_FETCH_ALIGN_CHECK_EN
      rpc = $urandom & 32'hFFFF_FFFC;
`else
      rpc = $urandom;
`endif
      cycle(st, rd, rpc, rdy);
    end

    // Misaligned redirect
    do_reset();
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
`ifdef IF_FETCH_ALIGN_CHECK_EN
    chk("tp_fault_sticky", {31'b0, fault}, 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    chk("tp_fault_ignores_redir", {31'b0, imem.imem_req}, 32'd0);
`else
    chk("tp_misalign_forced", pc_address_out, 32'h0000_010C);
`endif
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
